sreg_wb_arbiter: RTL and testbench
==================================

Name: sreg_wb_arbiter

Overview:
- Writeback stage directly upstream of the scalar register file. It merges two result streams onto the regfile's single write port.
  - Single-cycle ALU stream: priority, no backpressure.
  - Long-latency LSU/multi-cycle stream: valid/ready, buffered in a small FIFO.
- Emits one registered write per cycle: rd address, data and write-enable.
- An age counter forces an ALU stall so buffered LSU results cannot starve.

Parameters:
- DATA_WIDTH, 32, width of written data.
- LSU_DEPTH, 4, LSU FIFO entries; power of 2, >=2.
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may lose arbitration before alu_stall_o asserts; >=1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid_i  in  1  ALU result valid this cycle.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  DATA_WIDTH  ALU result.
- alu_stall_o  out  1  upstream must not assert alu_valid_i this cycle.
- lsu_valid_i  in  1  LSU result valid.
- lsu_ready_o  out  1  FIFO can accept.
- lsu_rd_i  in  5  LSU destination register.
- lsu_data_i  in  DATA_WIDTH  LSU result.
- wb_rd_o  out  5  regfile write address.
- wb_data_o  out  DATA_WIDTH  regfile write data.
- wb_en_o  out  1  regfile write enable.
- fifo_count_o  out  $clog2(LSU_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=1 at edge):
  - FIFO empty, age_q=0.
  - wb_en_o=0, wb_rd_o=0, wb_data_o=0.
  - alu_stall_o=0, fifo_count_o=0.
  - lsu_ready_o is forced 0 while rst is high.
  - Reset mid-operation discards all buffered entries and any pending output; no write is issued on the following cycle.
- rd==0 filtering:
  - ALU beat with rd=0 is ignored.
  - LSU beat with rd=0 completes the handshake but is not enqueued; count is unchanged.
- LSU enqueue:
  - lsu_ready_o = (count < LSU_DEPTH), combinational from registered count.
  - Enqueue on lsu_valid_i && lsu_ready_o.
  - When full, ready is 0 even if a dequeue occurs the same cycle (no pass-through).
- Arbitration, each cycle:
  - If alu_valid_i && rd!=0 && !alu_stall_o, select the ALU.
  - Otherwise, if the FIFO is non-empty, select the FIFO head and dequeue it at the edge.
  - Otherwise select nothing.
  - The selected request is registered onto wb_*_o.
  - wb_en_o=0 when nothing is selected; wb_rd_o and wb_data_o hold their last values.
- Latency:
  - ALU beat at edge N appears on wb_*_o in cycle N+1.
  - LSU beat enqueued at edge N is dequeued at edge N+1 at the earliest, so it appears in cycle N+2.
  - There is no same-cycle bypass from the LSU input to the output.
  - Simultaneous enqueue and dequeue keeps count unchanged; the FIFO pointers wrap modulo LSU_DEPTH.
- Starvation:
  - age_q increments at each edge where the FIFO is non-empty and not dequeued.
  - age_q clears at each dequeue, and when the FIFO is empty.
  - age_q saturates at STARVE_LIMIT.
  - alu_stall_o = (age_q == STARVE_LIMIT).
  - In a stall cycle the FIFO head wins, and age_q returns to 0.
  - alu_valid_i=1 during alu_stall_o is a protocol violation; the bench asserts on it.
- Ordering:
  - Writes reach the regfile in arbitration order.
  - WAW between the ALU and outstanding LSU results for the same rd is prevented by the issue-stage scoreboard, not by this block.

Decomposition:
- Shared package sreg_wb_pkg:
  - wb_req_t struct {rd[4:0], data[DATA_WIDTH-1:0]}.
  - REG_ADDR_W=5 constant.
- Sub-module sreg_wb_fifo: parameterised synchronous FIFO of wb_req_t.
  - Ports: push, pop, full, empty, count, head.
  - Implemented with registered read/write pointers carrying an extra wrap bit.

Test Plan:
- Reset: rst=1 for 2 cycles with lsu_valid_i=1 -> lsu_ready_o=0, wb_en_o=0, fifo_count_o=0; first cycle after release, lsu_ready_o=1.
- ALU only: alu_valid_i=1, rd=3, data=0x12345678 at edge 0 -> cycle 1 shows wb_en_o=1, wb_rd_o=3, wb_data_o=0x12345678; rd=0 beat -> wb_en_o=0.
- LSU latency: LSU beat rd=7, data=0xCAFEF00D at edge 0 with ALU idle -> fifo_count_o=1 in cycle 1; write visible in cycle 2.
- Starvation: ALU valid every cycle except when stalled; LSU beat rd=5, data=0xDEAD at edge 0:
  - ALU wins cycles 1..4.
  - alu_stall_o=1 in cycle 5.
  - Cycle 6 shows wb_rd_o=5, wb_data_o=0xDEAD.
  - alu_stall_o=0 in cycle 6.
- Full FIFO: hold ALU valid (stall honoured) and push 5 LSU beats back-to-back.
  - lsu_ready_o=0 once count=4.
  - The fifth beat is held off until a drain.
  - Written data order matches push order after wrap-around.
- Reset mid-operation: FIFO holding 3 entries, assert rst -> no write issued afterward, count=0, age_q=0.

Source files
------------

// File: rtl/sreg_wb_pkg.sv
// sreg_wb_pkg: shared types and constants for the scalar-regfile writeback arbiter.
//    REG_ADDR_W : register address width
//    WB_DATA_W  : default writeback data width
//    wb_req_t   : one pending regfile write {rd, data}
package sreg_wb_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int WB_DATA_W  = 32;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0]  data;
   } wb_req_t;
endpackage

// File: rtl/sreg_wb_fifo.sv
// sreg_wb_fifo: synchronous FIFO of writeback requests.
//    clk, rst    : clock, synchronous active-high reset
//    push / din  : write din at the tail (caller guarantees !full)
//    pop         : drop the head entry (caller guarantees !empty)
//    full, empty : occupancy flags
//    count       : number of stored entries
//    head        : oldest entry, valid while !empty
module sreg_wb_fifo
   import sreg_wb_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = wb_req_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  T                       din,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output T                       head
);
   localparam int AW = $clog2(DEPTH);
   T           mem [DEPTH];
   // pointers carry an extra wrap bit so full and empty are distinguishable
   logic [AW:0] wr_q, rd_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + (AW+1)'(1);
         if (pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk)
      if (push) mem[wr_q[AW-1:0]] <= din;
   assign count = wr_q - rd_q;
   assign empty = wr_q == rd_q;
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign head  = mem[rd_q[AW-1:0]];
endmodule

// File: rtl/sreg_wb_arbiter.sv
// sreg_wb_arbiter: merges the ALU and LSU result streams onto the regfile write port.
//    clk, rst                           : clock, synchronous active-high reset
//    alu_valid_i/alu_rd_i/alu_data_i    : single-cycle ALU result, no backpressure
//    alu_stall_o                        : ALU must not issue this cycle
//    lsu_valid_i/lsu_rd_i/lsu_data_i    : LSU result, handshaked with lsu_ready_o
//    lsu_ready_o                        : FIFO can accept an LSU beat
//    wb_rd_o/wb_data_o/wb_en_o          : registered regfile write
//    fifo_count_o                       : buffered LSU results
module sreg_wb_arbiter
   import sreg_wb_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int LSU_DEPTH    = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alu_valid_i,
   input  logic [REG_ADDR_W-1:0]      alu_rd_i,
   input  logic [DATA_WIDTH-1:0]      alu_data_i,
   output logic                       alu_stall_o,
   input  logic                       lsu_valid_i,
   output logic                       lsu_ready_o,
   input  logic [REG_ADDR_W-1:0]      lsu_rd_i,
   input  logic [DATA_WIDTH-1:0]      lsu_data_i,
   output logic [REG_ADDR_W-1:0]      wb_rd_o,
   output logic [DATA_WIDTH-1:0]      wb_data_o,
   output logic                       wb_en_o,
   output logic [$clog2(LSU_DEPTH):0] fifo_count_o
);
   localparam int AGW = $clog2(STARVE_LIMIT + 1);
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_WIDTH-1:0] data;
   } req_t;
   req_t           head;
   logic           full, empty, push, pop, alu_sel;
   logic [AGW-1:0] age_q;
   assign alu_stall_o = age_q == AGW'(STARVE_LIMIT);
   // no pass-through: a full FIFO refuses even when the head leaves this cycle
   assign lsu_ready_o = !rst && !full;
   // rd==0 LSU beats complete the handshake but are dropped
   assign push        = lsu_valid_i && lsu_ready_o && (lsu_rd_i != '0);
   assign alu_sel     = alu_valid_i && (alu_rd_i != '0) && !alu_stall_o;
   assign pop         = !alu_sel && !empty;
   sreg_wb_fifo #(
      .DEPTH (LSU_DEPTH),
      .T     (req_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({lsu_rd_i, lsu_data_i}),
      .full  (full),
      .empty (empty),
      .count (fifo_count_o),
      .head  (head)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         age_q     <= '0;
         wb_en_o   <= 1'b0;
         wb_rd_o   <= '0;
         wb_data_o <= '0;
      end else begin
         // age counts edges the buffered head loses, saturating at the stall point
         age_q   <= (empty || pop) ? '0 : alu_stall_o ? age_q : age_q + AGW'(1);
         wb_en_o <= alu_sel || pop;
         if (alu_sel) begin
            wb_rd_o   <= alu_rd_i;
            wb_data_o <= alu_data_i;
         end else if (pop) begin
            wb_rd_o   <= head.rd;
            wb_data_o <= head.data;
         end
      end
   end
endmodule

// File: tb/tb_sreg_wb_arbiter.sv
// tb_sreg_wb_arbiter: directed scoreboard bench for sreg_wb_arbiter.
module tb_sreg_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid_i, lsu_valid_i;
   logic [4:0]  alu_rd_i, lsu_rd_i;
   logic [31:0] alu_data_i, lsu_data_i;
   logic        alu_stall_o, lsu_ready_o, wb_en_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic [2:0]  fifo_count_o;
   int          tests = 0;
   int          fails = 0;
   logic [36:0] exp_q [$];
   logic [36:0] mon_e;
   int          li;
   logic        hs;

   sreg_wb_arbiter #(.DATA_WIDTH(32), .LSU_DEPTH(4), .STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid_i  (alu_valid_i),
      .alu_rd_i     (alu_rd_i),
      .alu_data_i   (alu_data_i),
      .alu_stall_o  (alu_stall_o),
      .lsu_valid_i  (lsu_valid_i),
      .lsu_ready_o  (lsu_ready_o),
      .lsu_rd_i     (lsu_rd_i),
      .lsu_data_i   (lsu_data_i),
      .wb_rd_o      (wb_rd_o),
      .wb_data_o    (wb_data_o),
      .wb_en_o      (wb_en_o),
      .fifo_count_o (fifo_count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
      exp_q.push_back({rd, d});
   endtask

   always @(negedge clk) begin
      if (wb_en_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", wb_rd_o, wb_data_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_rd", {27'd0, wb_rd_o}, {27'd0, mon_e[36:32]});
            chk("wb_data", wb_data_o, mon_e[31:0]);
         end
      end
   end

   always @(posedge clk) begin
      if (!rst && alu_valid_i && alu_stall_o) begin
         fails++;
         $error("FAIL alu_protocol: alu_valid_i=1 while alu_stall_o=1");
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
      lsu_valid_i = 1; lsu_rd_i = 9; lsu_data_i = 32'h1;
      rst = 1;
      repeat (2) begin
         tick;
         chk("rst_ready", lsu_ready_o, 0);
         chk("rst_wb_en", wb_en_o, 0);
         chk("rst_count", fifo_count_o, 0);
      end
      chk("rst_stall", alu_stall_o, 0);
      chk("rst_wb_rd", wb_rd_o, 0);
      chk("rst_wb_data", wb_data_o, 0);
      rst = 0;
      lsu_valid_i = 0;
      #1 chk("ready_after_rst", lsu_ready_o, 1);
      tick;
      chk("idle_wb_en", wb_en_o, 0);

      alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h12345678;
      expect_wr(3, 32'h12345678);
      tick;
      chk("alu_wb_en", wb_en_o, 1);
      chk("alu_wb_rd", wb_rd_o, 3);
      chk("alu_wb_data", wb_data_o, 32'h12345678);
      alu_rd_i = 0; alu_data_i = 32'hFFFF_FFFF;
      tick;
      chk("alu_rd0_wb_en", wb_en_o, 0);
      chk("alu_rd0_hold_rd", wb_rd_o, 3);
      chk("alu_rd0_hold_data", wb_data_o, 32'h12345678);
      alu_valid_i = 0;

      lsu_valid_i = 1; lsu_rd_i = 7; lsu_data_i = 32'hCAFEF00D;
      expect_wr(7, 32'hCAFEF00D);
      tick;
      lsu_valid_i = 0;
      chk("lsu_count1", fifo_count_o, 1);
      chk("lsu_no_bypass", wb_en_o, 0);
      tick;
      chk("lsu_wb_en", wb_en_o, 1);
      chk("lsu_wb_rd", wb_rd_o, 7);
      chk("lsu_wb_data", wb_data_o, 32'hCAFEF00D);
      chk("lsu_count0", fifo_count_o, 0);

      lsu_valid_i = 1; lsu_rd_i = 0; lsu_data_i = 32'h55;
      chk("lsu_rd0_ready", lsu_ready_o, 1);
      tick;
      lsu_valid_i = 0;
      chk("lsu_rd0_count", fifo_count_o, 0);
      tick;
      chk("lsu_rd0_wb_en", wb_en_o, 0);

      for (int c = 0; c < 8; c++) begin
         chk($sformatf("starve_stall_c%0d", c), alu_stall_o, (c == 5));
         alu_valid_i = (c != 5); alu_rd_i = 5'(10 + c); alu_data_i = 32'h100 + c;
         lsu_valid_i = (c == 0); lsu_rd_i = 5; lsu_data_i = 32'hDEAD;
         if (c != 5) expect_wr(alu_rd_i, alu_data_i);
         else expect_wr(5, 32'hDEAD);
         tick;
         if (c == 5) begin
            chk("starve_wb_rd", wb_rd_o, 5);
            chk("starve_wb_data", wb_data_o, 32'hDEAD);
            chk("starve_stall_clear", alu_stall_o, 0);
         end
      end
      alu_valid_i = 0; lsu_valid_i = 0;
      tick;

      li = 0;
      for (int c = 0; c < 8; c++) begin
         alu_valid_i = (c != 5); alu_rd_i = 5'(1 + c); alu_data_i = 32'h2000 + c;
         lsu_valid_i = (li < 5); lsu_rd_i = 5'(20 + li); lsu_data_i = 32'hA0 + li;
         if (c == 4) begin
            chk("full_count", fifo_count_o, 4);
            chk("full_ready", lsu_ready_o, 0);
         end
         if (c == 5) begin
            chk("full_stall", alu_stall_o, 1);
            chk("full_no_passthru", lsu_ready_o, 0);
         end
         if (c == 6) begin
            chk("drain_ready", lsu_ready_o, 1);
            chk("drain_count", fifo_count_o, 3);
         end
         if (c == 7) chk("wrap_count", fifo_count_o, 4);
         if (alu_valid_i) expect_wr(alu_rd_i, alu_data_i);
         else expect_wr(20, 32'hA0);
         hs = lsu_valid_i && lsu_ready_o;
         tick;
         if (hs) li++;
      end
      chk("full_beats_accepted", li, 5);
      alu_valid_i = 0; lsu_valid_i = 0;
      for (int i = 1; i < 5; i++) expect_wr(5'(20 + i), 32'hA0 + i);
      for (int w = 0; w < 40 && exp_q.size() != 0; w++) tick;
      chk("drain_done", exp_q.size(), 0);
      chk("drain_count0", fifo_count_o, 0);

      for (int c = 0; c < 3; c++) begin
         alu_valid_i = 1; alu_rd_i = 5'(11 + c); alu_data_i = 32'h3000 + c;
         expect_wr(alu_rd_i, alu_data_i);
         lsu_valid_i = 1; lsu_rd_i = 5'(25 + c); lsu_data_i = 32'hB0 + c;
         tick;
      end
      alu_valid_i = 0; lsu_valid_i = 0;
      chk("mid_count3", fifo_count_o, 3);
      rst = 1;
      tick;
      chk("mid_rst_wb_en", wb_en_o, 0);
      chk("mid_rst_count", fifo_count_o, 0);
      chk("mid_rst_age", 32'(dut.age_q), 0);
      chk("mid_rst_ready", lsu_ready_o, 0);
      rst = 0;
      repeat (4) begin
         tick;
         chk("post_rst_wb_en", wb_en_o, 0);
         chk("post_rst_count", fifo_count_o, 0);
      end
      chk("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
